// File: rtl/coin_dispense.sv
// coin_dispense: change-return dispenser. Issues a refund (in 25-paise units)
// as a sequence of coins, largest first, over a valid/ready handshake.
// Coin codes: 00=25p, 01=50p, 10=1R, 11=no coin.
// Optional stalled-handshake abort: define COIN_DISPENSE_TIMEOUT_EN.
module coin_dispense #(
    parameter int unsigned AW          = 4,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_in,
    input  logic [AW-1:0] amount_in,
    input  logic          coin_ready_in,
    output logic          coin_valid_out,
    output logic [1:0]    coin_out,
    output logic          busy_out,
    output logic          done_out,
    output logic          err_out,
    output logic [AW-1:0] rem_out,
    output logic [3:0]    coin_cnt_out
);

    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;

    // Elaboration-time sanity checks on configuration.
    if (GAP_CYC < 1) begin : g_gap_chk
        $error("coin_dispense: GAP_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_to_chk
        $error("coin_dispense: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   rem_q, rem_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [1:0]      coin_sel;
    logic [AW-1:0]   coin_units;

`ifdef COIN_DISPENSE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]   to_q, to_d;
    logic            err_q, err_d;
`endif

    // Greedy coin choice on the remaining amount; never exceeds rem.
    always_comb begin
        coin_sel   = 2'b00;
        coin_units = AW'(1);
        if (32'(rem_q) >= 32'd4) begin
            coin_sel   = 2'b10;
            coin_units = AW'(4);
        end else if (32'(rem_q) >= 32'd2) begin
            coin_sel   = 2'b01;
            coin_units = AW'(2);
        end
    end

    // Next-state and register updates for the dispense sequence.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        gap_d   = '0;
`ifdef COIN_DISPENSE_TIMEOUT_EN
        to_d    = '0;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    rem_d   = amount_in;
                    cnt_d   = '0;
                    state_d = (amount_in == '0) ? DONE : OFFER;
                end
            end
            OFFER: begin
                if (coin_ready_in) begin
                    rem_d   = rem_q - coin_units;
                    cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                    state_d = (rem_q == coin_units) ? DONE : GAP;
                end
`ifdef COIN_DISPENSE_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TW'(1);
                end
`endif
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) begin
                    state_d = OFFER;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

`ifdef COIN_DISPENSE_TIMEOUT_EN
    // Stall counter and abort flag; the flag is high only in the DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

    assign coin_valid_out = (state_q == OFFER);
    assign coin_out       = (state_q == OFFER) ? coin_sel : 2'b11;
    assign busy_out       = (state_q != IDLE);
    assign done_out       = (state_q == DONE);
    assign rem_out        = rem_q;
    assign coin_cnt_out   = cnt_q;

endmodule

// File: tb/tb_coin_dispense.sv
// tb_coin_dispense: scoreboard bench for coin_dispense (AW=4, GAP_CYC=2,
// TIMEOUT_CYC=8). Timeout scenario runs only with COIN_DISPENSE_TIMEOUT_EN.
module tb_coin_dispense;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_in;
    logic [3:0] amount_in;
    logic       coin_ready_in;
    logic       coin_valid_out;
    logic [1:0] coin_out;
    logic       busy_out;
    logic       done_out;
    logic       err_out;
    logic [3:0] rem_out;
    logic [3:0] coin_cnt_out;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [1:0]  exp_q[$];

    coin_dispense #(.AW(4), .GAP_CYC(2), .TIMEOUT_CYC(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_in       (start_in),
        .amount_in      (amount_in),
        .coin_ready_in  (coin_ready_in),
        .coin_valid_out (coin_valid_out),
        .coin_out       (coin_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .err_out        (err_out),
        .rem_out        (rem_out),
        .coin_cnt_out   (coin_cnt_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clock);
    endtask

    // Scoreboard: every offered coin must match the queue head; pop on accept.
    task automatic mon();
        if (coin_valid_out) begin
            check("offer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("coin", 32'(coin_out), 32'(exp_q[0]));
                if (coin_ready_in) void'(exp_q.pop_front());
            end
        end else begin
            check("coin_idle_code", 32'(coin_out), 32'h3);
        end
    endtask

    task automatic run(input string nm, input int n, input logic [3:0] amt,
                       input logic [31:0] rpat, input logic [31:0] spat,
                       input logic [3:0] amt2,
                       input logic [31:0] ev, input logic [31:0] ed,
                       input logic [31:0] eb, input logic [31:0] ee,
                       input logic [3:0] erem, input logic [3:0] ecnt);
        logic [31:0] v, d, b, e;
        v = '0; d = '0; b = '0; e = '0;
        start_in      = 1'b1;
        amount_in     = amt;
        coin_ready_in = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick();
            start_in      = spat[n-k];
            coin_ready_in = rpat[n-k];
            if (k == 1) amount_in = amt2;
            mon();
            v = {v[30:0], coin_valid_out};
            d = {d[30:0], done_out};
            b = {b[30:0], busy_out};
            e = {e[30:0], err_out};
        end
        start_in = 1'b0;
        check({nm, "_valid"}, v, ev);
        check({nm, "_done"},  d, ed);
        check({nm, "_busy"},  b, eb);
        check({nm, "_err"},   e, ee);
        check({nm, "_rem"},   32'(rem_out), 32'(erem));
        check({nm, "_cnt"},   32'(coin_cnt_out), 32'(ecnt));
    endtask

    initial begin
        logic seen_done;
        reset = 1'b1; start_in = 1'b0; amount_in = '0; coin_ready_in = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(coin_valid_out), 32'd0);
        check("rst_coin",  32'(coin_out), 32'h3);
        check("rst_busy",  32'(busy_out), 32'd0);
        check("rst_done",  32'(done_out), 32'd0);
        check("rst_err",   32'(err_out), 32'd0);
        check("rst_rem",   32'(rem_out), 32'd0);
        check("rst_cnt",   32'(coin_cnt_out), 32'd0);
        reset = 1'b0;
        tick();

        // 7 units: 1R, 50p, 25p with two gap cycles between offers.
        exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        run("amt7", 9, 4'd7, 32'h1FF, 32'h0, 4'd7,
            32'b100100100, 32'b000000010, 32'b111111110, 32'h0, 4'd0, 4'd3);
        check("amt7_drain", 32'(exp_q.size()), 32'd0);

        // Zero amount goes straight to DONE.
        run("amt0", 3, 4'd0, 32'h7, 32'h0, 4'd0,
            32'b000, 32'b100, 32'b100, 32'h0, 4'd0, 4'd0);

        // 50p offer stalled five cycles, accepted on the sixth.
        exp_q.push_back(2'b01);
        run("stall", 8, 4'd2, 32'b00000111, 32'h0, 4'd2,
            32'b11111100, 32'b00000010, 32'b11111110, 32'h0, 4'd0, 4'd1);
        check("stall_drain", 32'(exp_q.size()), 32'd0);

        // Restart attempt during OFFER is ignored.
        exp_q.push_back(2'b10); exp_q.push_back(2'b00);
        run("restart", 6, 4'd5, 32'h3F, 32'b100000, 4'd3,
            32'b100100, 32'b000010, 32'b111110, 32'h0, 4'd0, 4'd2);
        check("restart_drain", 32'(exp_q.size()), 32'd0);

        // Reset in the gap after the first acceptance abandons the refund.
        exp_q.push_back(2'b10); exp_q.push_back(2'b10); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b00);
        start_in = 1'b1; amount_in = 4'd15; coin_ready_in = 1'b1;
        tick();
        start_in = 1'b0;
        mon();
        check("rst_mid_first_valid", 32'(coin_valid_out), 32'd1);
        tick();
        mon();
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 32'(coin_valid_out), 32'd0);
        check("rst_mid_coin",  32'(coin_out), 32'h3);
        check("rst_mid_busy",  32'(busy_out), 32'd0);
        check("rst_mid_rem",   32'(rem_out), 32'd0);
        check("rst_mid_cnt",   32'(coin_cnt_out), 32'd0);
        check("rst_mid_left",  32'(exp_q.size()), 32'd4);
        exp_q.delete();
        reset = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            mon();
            seen_done = seen_done | done_out;
        end
        check("rst_mid_no_done", 32'(seen_done), 32'd0);

`ifdef COIN_DISPENSE_TIMEOUT_EN
        // 1R accepted, then 50p offer stalls until the 8-cycle abort.
        exp_q.push_back(2'b10); exp_q.push_back(2'b01);
        run("timeout", 13, 4'd6, 32'b1000000000000, 32'h0, 4'd6,
            32'b1001111111100, 32'b0000000000010, 32'b1111111111110,
            32'b0000000000010, 4'd2, 4'd1);
        check("timeout_left", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/coin_dispense.md
Name: coin_dispense

Overview:
Change-return dispenser. It is the output-side counterpart of the coin collector and uses the same 2-bit coin code (00=25 paise, 01=50 paise, 10=1 Rupee, 11=no coin). It accepts a refund amount in 25-paise units and issues coins to the ejector mechanism one at a time, largest denomination first, over a valid/ready handshake. It sits between the vend controller and the coin-ejector driver.

Parameters:
AW, 4, width of amount in 25-paise units (max refund (2^AW-1)*25 paise).
GAP_CYC, 2, idle cycles between consecutive coins for ejector settle (minimum 1).
TIMEOUT_CYC, 16, stalled-handshake limit in cycles (used only with the optional feature).

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high.
start_in  input  1  request a refund; sampled only in IDLE.
amount_in  input  AW  refund in 25-paise units; sampled with start_in.
coin_ready_in  input  1  ejector accepts the offered coin this cycle.
coin_valid_out  output  1  coin offer valid.
coin_out  output  2  coin code; 2'b11 whenever coin_valid_out=0.
busy_out  output  1  transaction in progress.
done_out  output  1  one-cycle pulse at end of transaction.
err_out  output  1  one-cycle pulse with done_out on timeout abort (optional feature only; tied 0 otherwise).
rem_out  output  AW  remaining units still to dispense.
coin_cnt_out  output  4  coins dispensed in the current or last transaction, saturating at 15.

Behaviour:
Reset values, applied on the edge where reset=1:
- state=IDLE.
- coin_valid_out=0, coin_out=2'b11.
- busy_out=0, done_out=0, err_out=0.
- rem_out=0, coin_cnt_out=0.
- Reset mid-transaction abandons any in-flight offer. Outputs return to reset values on that edge.

The block is a Moore FSM. All outputs are registered or decoded from state and registers only. There is no combinational path from inputs to outputs.

States:
- IDLE: busy=0. If start_in=1 at an edge:
  - rem <= amount_in, coin_cnt <= 0.
  - Next state is DONE if amount_in=0, else OFFER.
  - The first coin_valid_out is therefore high in the cycle after the start edge.
- OFFER: coin_valid_out=1.
  - coin_out is greedy on rem: rem>=4 gives 10; rem>=2 gives 01; otherwise 00.
  - coin_out and coin_valid_out stay stable while coin_ready_in=0.
  - On an edge with coin_ready_in=1: rem <= rem minus the coin value (4, 2 or 1 units) and coin_cnt increments (saturating).
  - After acceptance, next state is DONE if the new rem is 0, else GAP.
- GAP: coin_valid_out=0. Count GAP_CYC cycles, then go to OFFER.
- DONE: done_out=1 for exactly one cycle, busy_out=1, then go to IDLE.
  - rem_out and coin_cnt_out hold their final values in IDLE until the next start.

Boundary rules:
- start_in is ignored outside IDLE.
- amount_in is captured once; later changes have no effect.
- The subtraction never underflows, because greedy selection guarantees coin value <= rem.
- busy_out=1 in every state except IDLE.
- coin_ready_in has no effect outside OFFER.

Optional Feature:
Macro COIN_DISPENSE_TIMEOUT_EN.

When defined:
- A counter runs in OFFER and counts consecutive cycles with coin_valid_out=1 and coin_ready_in=0.
- When the count reaches TIMEOUT_CYC, the next edge moves the FSM to DONE without accepting the coin. done_out and err_out both pulse in that DONE cycle.
- rem_out retains the undispensed amount so the controller can log or retry.
- The counter clears on every acceptance and on leaving OFFER.

When not defined:
- No timeout; the FSM waits in OFFER indefinitely.
- err_out is constant 0.

Test Plan:
1. amount_in=7, coin_ready_in held 1, GAP_CYC=2. Required: offers 10, 01, 00, each for one cycle, separated by 2 idle cycles. done pulse directly after the third acceptance. coin_cnt_out=3, rem_out=0.
2. amount_in=0 with start. Required: coin_valid_out never asserts. done_out=1 in the cycle after the start edge. busy_out=1 for that one cycle only.
3. amount_in=2, coin_ready_in low for 5 cycles, then high. Required: coin_out=01 with valid held 6 cycles. Accept on the 6th cycle, then done. coin_cnt_out=1.
4. amount_in=15, reset asserted one cycle after the first acceptance. Required: next edge gives coin_valid_out=0, coin_out=11, busy_out=0, rem_out=0, coin_cnt_out=0. No done_out.
5. start_in pulsed again during OFFER with amount_in=3 (initial amount_in=5). Required: ignored. Dispenses 10 then 00 only. Total coin_cnt_out=2.
6. (COIN_DISPENSE_TIMEOUT_EN, TIMEOUT_CYC=8) amount_in=6, first coin accepted, coin_ready_in then stuck 0. Required: after 8 cycles of the 01 offer, done_out=err_out=1 for one cycle. rem_out=2, coin_cnt_out=1, then IDLE.
